kernel_prueba_example_multi_counter: RTL and testbench

- N-channel up/down counter bank, the successor to the single-channel example counter.
- Each channel has a per-channel load, increment and decrement with a programmable step size.
- Wrap or saturate mode is selected by parameter.
- Registered is_zero/is_max flags and a bank-wide all_zero flag feed the kernel's transfer-length and loop-control logic.

---
 rtl/kernel_prueba_example_multi_counter.sv | 117 +++++++++++
 tb/tb_kernel_prueba_example_multi_counter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_prueba_example_multi_counter.sv
// N-channel up/down counter bank with per-channel load, step size and
// registered zero/max flags. Wrap or saturate arithmetic is chosen by
// C_SATURATE. Optional sticky overflow/underflow flags are enabled by
// defining KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN.
module kernel_prueba_example_multi_counter #(
  parameter int unsigned        C_NUM_CH     = 2,
  parameter int unsigned        C_WIDTH      = 8,
  parameter int unsigned        C_STEP_WIDTH = 4,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0,
  parameter int unsigned        C_SATURATE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clken,
  input  logic [C_NUM_CH-1:0]            load,
  input  logic [C_NUM_CH-1:0]            incr,
  input  logic [C_NUM_CH-1:0]            decr,
  input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] step,
  input  logic [C_NUM_CH*C_WIDTH-1:0]    load_value,
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
  input  logic [C_NUM_CH-1:0]            ovf_clr,
  output logic [C_NUM_CH-1:0]            ovf,
  output logic [C_NUM_CH-1:0]            unf,
`endif
  output logic [C_NUM_CH*C_WIDTH-1:0]    count,
  output logic [C_NUM_CH-1:0]            is_zero,
  output logic [C_NUM_CH-1:0]            is_max,
  output logic                           all_zero
);

  localparam int unsigned        SUM_W     = C_WIDTH + 1;
  localparam logic [C_WIDTH-1:0] ALL_ONES  = '1;
  localparam logic               INIT_ZERO = (C_INIT == '0);
  localparam logic               INIT_MAX  = (C_INIT == ALL_ONES);

  logic [C_NUM_CH*C_WIDTH-1:0] count_nxt;
  logic [C_NUM_CH-1:0]         zero_nxt;
  logic [C_NUM_CH-1:0]         max_nxt;
  logic [C_WIDTH-1:0]          cur;
  logic [C_WIDTH-1:0]          stp;
  logic [C_WIDTH-1:0]          nxt;
  logic [SUM_W-1:0]            sum;
  logic [SUM_W-1:0]            dif;
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
  logic [C_NUM_CH-1:0]         ovf_set;
  logic [C_NUM_CH-1:0]         unf_set;
`endif

  // Per-channel next value and the flags derived from it
  always_comb begin
    count_nxt = count;
    zero_nxt  = '0;
    max_nxt   = '0;
    cur       = '0;
    stp       = '0;
    nxt       = '0;
    sum       = '0;
    dif       = '0;
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
    ovf_set   = '0;
    unf_set   = '0;
`endif
    for (int i = 0; i < int'(C_NUM_CH); i++) begin
      cur = count[i*C_WIDTH +: C_WIDTH];
      stp = C_WIDTH'(step[i*C_STEP_WIDTH +: C_STEP_WIDTH]);
      // Extra top bit carries out on overflow and borrows on underflow
      sum = {1'b0, cur} + {1'b0, stp};
      dif = {1'b0, cur} - {1'b0, stp};
      nxt = cur;
      if (load[i]) begin
        nxt = load_value[i*C_WIDTH +: C_WIDTH];
      end else if (incr[i] && !decr[i]) begin
        nxt = ((C_SATURATE != 0) && sum[C_WIDTH]) ? ALL_ONES : sum[C_WIDTH-1:0];
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
        ovf_set[i] = sum[C_WIDTH];
`endif
      end else if (decr[i] && !incr[i]) begin
        nxt = ((C_SATURATE != 0) && dif[C_WIDTH]) ? '0 : dif[C_WIDTH-1:0];
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
        unf_set[i] = dif[C_WIDTH];
`endif
      end
      count_nxt[i*C_WIDTH +: C_WIDTH] = nxt;
      zero_nxt[i] = (nxt == '0);
      max_nxt[i]  = (nxt == ALL_ONES);
    end
  end

  // Count and flag registers, updated together so they always agree
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= {C_NUM_CH{C_INIT}};
      is_zero  <= {C_NUM_CH{INIT_ZERO}};
      is_max   <= {C_NUM_CH{INIT_MAX}};
      all_zero <= INIT_ZERO;
    end else if (clken) begin
      count    <= count_nxt;
      is_zero  <= zero_nxt;
      is_max   <= max_nxt;
      all_zero <= &zero_nxt;
    end
  end

`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
  // Sticky overflow/underflow; a new event in the same cycle beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
      unf <= '0;
    end else if (clken) begin
      ovf <= ovf_set | (ovf & ~ovf_clr);
      unf <= unf_set | (unf & ~ovf_clr);
    end
  end
`endif

endmodule

// File: tb/tb_kernel_prueba_example_multi_counter.sv
// Self-checking bench: a wrap instance and a saturate instance share inputs
// and are compared each cycle against an integer-arithmetic model.
// Sticky-flag checks are compiled when KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN is set.
module tb_kernel_prueba_example_multi_counter;

  logic       clk = 1'b0;
  logic       rst, clken;
  logic [1:0] load, incr, decr;
  logic [3:0] step;
  logic [7:0] load_value;
  logic [1:0] ovf_clr;

  logic [7:0] count_w, count_s;
  logic [1:0] zero_w, zero_s, max_w, max_s;
  logic       az_w, az_s;
  logic [1:0] ovf_w, unf_w, ovf_s, unf_s;

  int checks = 0;
  int errors = 0;

  // Model state: [mode][channel], mode 0 = wrap, 1 = saturate
  int mdl  [2][2];
  bit movf [2][2];
  bit munf [2][2];

  always #5 clk = ~clk;

  kernel_prueba_example_multi_counter #(
    .C_NUM_CH(2), .C_WIDTH(4), .C_STEP_WIDTH(2), .C_INIT(4'd0), .C_SATURATE(0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .step(step), .load_value(load_value),
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf_w), .unf(unf_w),
`endif
    .count(count_w), .is_zero(zero_w), .is_max(max_w), .all_zero(az_w)
  );

  kernel_prueba_example_multi_counter #(
    .C_NUM_CH(2), .C_WIDTH(4), .C_STEP_WIDTH(2), .C_INIT(4'd0), .C_SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .step(step), .load_value(load_value),
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf_s), .unf(unf_s),
`endif
    .count(count_s), .is_zero(zero_s), .is_max(max_s), .all_zero(az_s)
  );

`ifndef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
  assign ovf_w = 2'b00;
  assign unf_w = 2'b00;
  assign ovf_s = 2'b00;
  assign unf_s = 2'b00;
`endif

  // Apply the behavioural rules to the model for one clock edge
  function automatic void model_edge();
    for (int m = 0; m < 2; m++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rst) begin
          mdl[m][ch]  = 0;
          movf[m][ch] = 1'b0;
          munf[m][ch] = 1'b0;
        end else if (clken) begin
          int v;
          int s;
          bit o;
          bit u;
          v = mdl[m][ch];
          s = int'(step[ch*2 +: 2]);
          o = 1'b0;
          u = 1'b0;
          if (load[ch]) v = int'(load_value[ch*4 +: 4]);
          else if (incr[ch] && !decr[ch]) begin v = v + s; o = (v > 15); end
          else if (decr[ch] && !incr[ch]) begin v = v - s; u = (v < 0); end
          if (m == 1) begin
            if (o) v = 15;
            if (u) v = 0;
          end else begin
            v = (v + 16) % 16;
          end
          mdl[m][ch]  = v;
          movf[m][ch] = o ? 1'b1 : (ovf_clr[ch] ? 1'b0 : movf[m][ch]);
          munf[m][ch] = u ? 1'b1 : (ovf_clr[ch] ? 1'b0 : munf[m][ch]);
        end
      end
    end
  endfunction

  // Expected {count, is_zero, is_max, all_zero, ovf, unf} for one instance
  function automatic logic [16:0] exp_vec(int m);
    logic [7:0] c;
    logic [1:0] z, x, o, u;
    for (int ch = 0; ch < 2; ch++) begin
      c[ch*4 +: 4] = 4'(mdl[m][ch]);
      z[ch] = (mdl[m][ch] == 0);
      x[ch] = (mdl[m][ch] == 15);
      o[ch] = movf[m][ch];
      u[ch] = munf[m][ch];
    end
`ifndef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
    o = 2'b00;
    u = 2'b00;
`endif
    return {c, z, x, z[0] & z[1], o, u};
  endfunction

  function automatic logic [16:0] dut_vec(int m);
    if (m == 0) return {count_w, zero_w, max_w, az_w, ovf_w, unf_w};
    return {count_s, zero_s, max_s, az_s, ovf_s, unf_s};
  endfunction

  task automatic idle();
    rst = 1'b0; clken = 1'b1; load = '0; incr = '0; decr = '0;
    step = '0; load_value = '0; ovf_clr = '0;
  endtask

  // Advance one edge, update the model, then settle before sampling
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      load = 2'($urandom); incr = 2'($urandom); decr = 2'($urandom);
      step = 4'($urandom); load_value = 8'($urandom); ovf_clr = 2'($urandom);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL reset m=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
        end
      end
      checks++;
      if (count_w !== 8'h00 || zero_w !== 2'b11 || az_w !== 1'b1) begin
        errors++;
        $display("FAIL reset_const count=%h zero=%b az=%b", count_w, zero_w, az_w);
      end
    end
    idle();
    load = 2'b11; load_value = 8'h05;
    tick();
    checks++;
    if (count_w !== 8'h05 || zero_w !== 2'b10 || az_w !== 1'b0) begin
      errors++;
      $display("FAIL load_const count=%h zero=%b az=%b exp 05 10 0", count_w, zero_w, az_w);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== exp_vec(m)) begin
        errors++;
        $display("FAIL load m=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_wrap();
    idle(); load = 2'b01; load_value = 8'h0E; tick();
    idle(); incr = 2'b01; step = 4'h3; tick();
    checks++;
    if (count_w[3:0] !== 4'd1 || max_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up ch0=%0d max=%b exp 1 0", count_w[3:0], max_w[0]);
    end
    idle(); decr = 2'b01; step = 4'h2; tick();
    checks++;
    if (count_w[3:0] !== 4'd15 || max_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down ch0=%0d max=%b exp 15 1", count_w[3:0], max_w[0]);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== exp_vec(m)) begin
        errors++;
        $display("FAIL wrap m=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_saturate();
    idle(); load = 2'b11; load_value = 8'h1D; tick();
    idle(); incr = 2'b01; decr = 2'b10; step = 4'hF; tick();
    checks++;
    if (count_s !== 8'h0F || zero_s[1] !== 1'b1 || max_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_clamp count=%h zero=%b max=%b exp 0f", count_s, zero_s, max_s);
    end
    idle(); incr = 2'b01; step = 4'h1; tick();
    checks++;
    if (count_s[3:0] !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold ch0=%0d exp 15", count_s[3:0]);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== exp_vec(m)) begin
        errors++;
        $display("FAIL sat m=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_priority();
    idle(); load = 2'b11; incr = 2'b11; decr = 2'b11; step = 4'hF; load_value = 8'h77;
    tick();
    for (int c = 0; c < 6; c++) begin
      idle(); incr = 2'b11; step = 4'hF;
      if (c < 3) decr = 2'b11;
      else clken = 1'b0;
      if (c > 0) tick();
      checks++;
      if (count_w !== 8'h77 || count_s !== 8'h77) begin
        errors++;
        $display("FAIL priority c=%0d wrap=%h sat=%h exp 77", c, count_w, count_s);
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL priority m=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(); load = 2'b01; load_value = 8'h00; tick();
    for (int c = 1; c <= 3; c++) begin
      idle(); incr = 2'b01; step = 4'h1;
      if (c == 3) rst = 1'b1;
      tick();
      checks++;
      if (count_w[3:0] !== ((c == 3) ? 4'd0 : 4'(c))) begin
        errors++;
        $display("FAIL reset_mid c=%0d ch0=%0d", c, count_w[3:0]);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      clken = ($urandom_range(0, 7) != 0);
      load = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      incr = 2'($urandom); decr = 2'($urandom);
      step = 4'($urandom); load_value = 8'($urandom);
      ovf_clr = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          errors++;
          $display("FAIL random c=%0d m=%0d got=%h exp=%h", c, m, dut_vec(m), exp_vec(m));
        end
      end
    end
    idle();
  endtask

`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
  task automatic test_sticky();
    idle(); rst = 1'b1; tick();
    idle(); load = 2'b01; load_value = 8'h0F; tick();
    idle(); incr = 2'b01; step = 4'h1; tick();
    checks++;
    if (ovf_w[0] !== 1'b1 || count_w[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL sticky_set ovf=%b ch0=%0d exp 1 0", ovf_w[0], count_w[3:0]);
    end
    idle(); load = 2'b01; load_value = 8'h0F; tick();
    idle(); incr = 2'b01; step = 4'h1; ovf_clr = 2'b01; tick();
    checks++;
    if (ovf_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins ovf=%b exp 1", ovf_w[0]);
    end
    idle(); ovf_clr = 2'b01; tick();
    checks++;
    if (ovf_w[0] !== 1'b0 || ovf_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr wrap=%b sat=%b exp 0", ovf_w[0], ovf_s[0]);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (dut_vec(m) !== exp_vec(m)) begin
        errors++;
        $display("FAIL sticky m=%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m));
      end
    end
    idle();
  endtask
`endif

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_reset_mid();
`ifdef KERNEL_PRUEBA_MULTI_COUNTER_STICKY_EN
    test_sticky();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
